icon_blit_ctrl: RTL and testbench

ICON_BLIT_CTRL -- requirements
Module: icon_blit_ctrl

---
 rtl/icon_blit_ctrl.sv | 170 +++++++++++++++++
 tb/tb_icon_blit_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/icon_blit_ctrl.sv
// Icon-to-framebuffer blitter: walks an IMG_W x IMG_H icon ROM in raster order and emits clipped framebuffer writes.
// Optional colour-key transparency (24'hFF00FF) is enabled by defining BLIT_TRANSPARENT_EN.
module icon_blit_ctrl #(
    parameter int IMG_W = 48,
    parameter int IMG_H = 48,
    parameter int FB_W  = 640,
    parameter int FB_H  = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [9:0]  dst_x,
    input  logic [9:0]  dst_y,
    output logic        busy,
    output logic        done,
    output logic [9:0]  rom_x,
    output logic [9:0]  rom_y,
    input  logic [7:0]  rom_r,
    input  logic [7:0]  rom_g,
    input  logic [7:0]  rom_b,
    output logic        fb_we,
    output logic [9:0]  fb_x,
    output logic [9:0]  fb_y,
    output logic [23:0] fb_rgb,
    input  logic        fb_ready
);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    // Handshake: a write transfers only when fb_we and fb_ready are both high;
    // while fb_we is high and fb_ready low, fb_we/fb_x/fb_y/fb_rgb hold.
    state_t      state, state_nxt;
    logic [9:0]  dx, dy;
    logic        p_valid, p_last;
    logic [9:0]  p_x, p_y;
    logic        s_valid, s_last;
    logic [9:0]  s_x, s_y;
    logic [23:0] s_rgb;
    logic        o_valid, o_we, o_last;
    logic        accept, issue, fetch, addr_last;
    logic        retire, out_free, load_o, to_skid;
    logic [9:0]  src_x, src_y;
    logic [23:0] src_rgb;
    logic        src_last, src_key, src_we;
    logic [10:0] sum_x, sum_y;

    // A fetch of (0,0) is implied by the accepted start: the ROM already sees address 0 in IDLE.
    assign addr_last = (rom_x == 10'(IMG_W - 1)) && (rom_y == 10'(IMG_H - 1));
    assign accept    = (state == IDLE) && start && !done;
    assign retire    = o_valid && (!o_we || fb_ready);
    assign out_free  = !o_valid || retire;
    assign issue     = (state == RUN) && !s_valid && !(p_valid && !out_free);
    assign fetch     = accept || issue;
    assign load_o    = out_free && (s_valid || p_valid);
    assign to_skid   = p_valid && !s_valid && !out_free;
    assign busy      = (state != IDLE);
    assign fb_we     = o_valid && o_we;

    always_comb begin
        src_x    = p_x;
        src_y    = p_y;
        src_rgb  = {rom_r, rom_g, rom_b};
        src_last = p_last;
        if (s_valid) begin
            src_x    = s_x;
            src_y    = s_y;
            src_rgb  = s_rgb;
            src_last = s_last;
        end
    end

`ifdef BLIT_TRANSPARENT_EN
    assign src_key = (src_rgb == 24'hFF00FF);
`else
    assign src_key = 1'b0;
`endif

    // Clip on the full 11-bit sums so coordinates past 1023 never alias back on-screen.
    assign sum_x  = {1'b0, dx} + {1'b0, src_x};
    assign sum_y  = {1'b0, dy} + {1'b0, src_y};
    assign src_we = (sum_x < 11'(FB_W)) && (sum_y < 11'(FB_H)) && !src_key;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = addr_last ? DRAIN : RUN;
            RUN:     if (issue && addr_last) state_nxt = DRAIN;
            DRAIN:   if (retire && o_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            done  <= 1'b0;
            dx    <= '0;
            dy    <= '0;
            rom_x <= '0;
            rom_y <= '0;
        end else begin
            state <= state_nxt;
            done  <= (state == DRAIN) && retire && o_last;
            if (accept) begin
                dx <= dst_x;
                dy <= dst_y;
            end
            if (state_nxt == IDLE) begin
                rom_x <= '0;
                rom_y <= '0;
            end else if (fetch && !addr_last) begin
                if (rom_x == 10'(IMG_W - 1)) begin
                    rom_x <= '0;
                    rom_y <= rom_y + 10'd1;
                end else begin
                    rom_x <= rom_x + 10'd1;
                end
            end
        end
    end

    // Pipeline: fetch -> (ROM latency) -> optional skid -> output slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_valid <= 1'b0;
            p_last  <= 1'b0;
            p_x     <= '0;
            p_y     <= '0;
            s_valid <= 1'b0;
            s_last  <= 1'b0;
            s_x     <= '0;
            s_y     <= '0;
            s_rgb   <= '0;
            o_valid <= 1'b0;
            o_we    <= 1'b0;
            o_last  <= 1'b0;
            fb_x    <= '0;
            fb_y    <= '0;
            fb_rgb  <= '0;
        end else begin
            p_valid <= fetch;
            if (fetch) begin
                p_x    <= rom_x;
                p_y    <= rom_y;
                p_last <= addr_last;
            end
            if (to_skid) begin
                s_valid <= 1'b1;
                s_x     <= p_x;
                s_y     <= p_y;
                s_rgb   <= {rom_r, rom_g, rom_b};
                s_last  <= p_last;
            end else if (s_valid && out_free) begin
                s_valid <= 1'b0;
            end
            if (load_o) begin
                o_valid <= 1'b1;
                o_we    <= src_we;
                o_last  <= src_last;
                fb_x    <= sum_x[9:0];
                fb_y    <= sum_y[9:0];
                fb_rgb  <= src_rgb;
            end else if (retire) begin
                o_valid <= 1'b0;
                o_we    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_icon_blit_ctrl.sv
// Bench for icon_blit_ctrl: table of blits checked through an expected-write queue, plus reset/abort sequences.
module tb_icon_blit_ctrl;

    localparam int IMG_W = 48;
    localparam int IMG_H = 48;
    localparam int FB_W  = 640;
    localparam int FB_H  = 480;

`ifdef BLIT_TRANSPARENT_EN
    localparam int TR = 1;
`else
    localparam int TR = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [9:0]  dst_x = '0;
    logic [9:0]  dst_y = '0;
    logic        busy, done, fb_we;
    logic [9:0]  rom_x, rom_y, fb_x, fb_y;
    logic [7:0]  rom_r = '0;
    logic [7:0]  rom_g = '0;
    logic [7:0]  rom_b = '0;
    logic [23:0] fb_rgb;
    logic        fb_ready = 1'b1;

    icon_blit_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .FB_W(FB_W), .FB_H(FB_H)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dst_x(dst_x), .dst_y(dst_y),
        .busy(busy), .done(done), .rom_x(rom_x), .rom_y(rom_y),
        .rom_r(rom_r), .rom_g(rom_g), .rom_b(rom_b),
        .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_rgb(fb_rgb), .fb_ready(fb_ready)
    );

    // ---------------- clock / reset / cycle counter ----------------
    always #5 clk = ~clk;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- icon ROM model (one-cycle latency) ----------------
    function automatic logic [23:0] rom_pix(input int ix, input int iy);
        logic [7:0] r, g, b;
        if (ix == 3 && iy == 0) return 24'hFF00FF;
        r = 8'(ix * 5 + iy);
        g = 8'(iy * 3) ^ 8'(ix);
        b = 8'(ix + iy * 11);
        return {r, g, b};
    endfunction

    always @(posedge clk) {rom_r, rom_g, rom_b} <= rom_pix(int'(rom_x), int'(rom_y));

    // ---------------- fb_ready driver ----------------
    bit rnd_ready = 1'b0;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            fb_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // ---------------- scoreboard ----------------
    logic [43:0] exp_q[$];
    int n_vec = 0;
    int n_fail = 0;
    int t0 = 0;
    int wr_cnt = 0;
    int first_c = -1;
    int last_c = -1;
    int done_c = -1;
    bit prev_stall = 1'b0;
    logic [43:0] prev_w = '0;

    task automatic check(input string name, input int got, input int req);
        n_vec++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    always @(negedge clk) begin
        logic [43:0] w;
        if (!rst_n) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                n_vec++;
                if (fb_we !== 1'b1 || {fb_x, fb_y, fb_rgb} !== prev_w) begin
                    n_fail++;
                    $display("FAIL stall_hold: got we=%0b %h, required we=1 %h", fb_we, {fb_x, fb_y, fb_rgb}, prev_w);
                end
            end
            if (fb_we && fb_ready) begin
                wr_cnt++;
                if (first_c < 0) first_c = cyc - t0;
                last_c = cyc - t0;
                n_vec++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_write: got (%0d,%0d) %h, required none", fb_x, fb_y, fb_rgb);
                end else begin
                    w = exp_q.pop_front();
                    if ({fb_x, fb_y, fb_rgb} !== w) begin
                        n_fail++;
                        $display("FAIL write_data: got (%0d,%0d) %h, required (%0d,%0d) %h",
                                 fb_x, fb_y, fb_rgb, w[43:34], w[33:24], w[23:0]);
                    end
                end
            end
            if (done) begin
                if (done_c < 0) done_c = cyc - t0;
                check("busy_at_done", int'(busy), 0);
            end
            prev_stall = fb_we && !fb_ready;
            prev_w     = {fb_x, fb_y, fb_rgb};
        end
    end

    // ---------------- driver tasks ----------------
    typedef struct {
        int dx;
        int dy;
        bit rnd;
        bit restart;
        int exp_cnt;
        bit t_vis;
        int exp_first;
        int exp_last;
        int exp_done;
    } vec_t;

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_fb_we"}, int'(fb_we), 0);
        check({tag, "_rom_x"}, int'(rom_x), 0);
        check({tag, "_rom_y"}, int'(rom_y), 0);
        check({tag, "_fb_x"}, int'(fb_x), 0);
        check({tag, "_fb_y"}, int'(fb_y), 0);
        check({tag, "_fb_rgb"}, int'(fb_rgb), 0);
    endtask

    task automatic launch(input vec_t v);
        exp_q.delete();
        for (int iy = 0; iy < IMG_H; iy++) begin
            for (int ix = 0; ix < IMG_W; ix++) begin
                int x, y;
                x = v.dx + ix;
                y = v.dy + iy;
                if (x < FB_W && y < FB_H && !(TR == 1 && rom_pix(ix, iy) == 24'hFF00FF))
                    exp_q.push_back({10'(x), 10'(y), rom_pix(ix, iy)});
            end
        end
        rnd_ready = v.rnd;
        @(posedge clk);
        #1;
        start   = 1'b1;
        dst_x   = 10'(v.dx);
        dst_y   = 10'(v.dy);
        t0      = cyc;
        wr_cnt  = 0;
        first_c = -1;
        last_c  = -1;
        done_c  = -1;
        @(posedge clk);
        #1;
        start = 1'b0;
        dst_x = 10'($urandom_range(0, 1023));
        dst_y = 10'($urandom_range(0, 1023));
    endtask

    task automatic run_blit(input vec_t v);
        int n;
        launch(v);
        if (v.restart) begin
            repeat (99) @(posedge clk);
            #1;
            start = 1'b1;
            dst_x = 10'd5;
            dst_y = 10'd5;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        n = 0;
        while (done_c < 0 && n < 20000) begin
            @(posedge clk);
            n++;
        end
        check("done_seen", int'(done_c >= 0), 1);
        @(negedge clk);
        check("done_one_cycle", int'(done), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_rom_xy", int'({rom_x, rom_y}), 0);
        check("idle_fb_we", int'(fb_we), 0);
        check("write_count", wr_cnt, v.exp_cnt - (v.t_vis ? TR : 0));
        check("exp_left", exp_q.size(), 0);
        if (v.exp_first >= 0) check("first_write_cycle", first_c, v.exp_first);
        if (v.exp_last >= 0) check("last_write_cycle", last_c, v.exp_last);
        if (v.exp_done >= 0) check("done_cycle", done_c, v.exp_done);
    endtask

    // ---------------- test ----------------
    vec_t vt[7];
    vec_t va;

    initial begin
        vt[0] = '{dx:0,    dy:0,    rnd:0, restart:0, exp_cnt:2304, t_vis:1, exp_first:2,  exp_last:2305, exp_done:2306};
        vt[1] = '{dx:620,  dy:470,  rnd:0, restart:0, exp_cnt:200,  t_vis:1, exp_first:2,  exp_last:453,  exp_done:2306};
        vt[2] = '{dx:100,  dy:50,   rnd:1, restart:0, exp_cnt:2304, t_vis:1, exp_first:-1, exp_last:-1,   exp_done:-1};
        vt[3] = '{dx:10,   dy:20,   rnd:0, restart:1, exp_cnt:2304, t_vis:1, exp_first:2,  exp_last:2305, exp_done:2306};
        vt[4] = '{dx:639,  dy:479,  rnd:0, restart:0, exp_cnt:1,    t_vis:0, exp_first:2,  exp_last:2,    exp_done:2306};
        vt[5] = '{dx:600,  dy:0,    rnd:1, restart:0, exp_cnt:1920, t_vis:1, exp_first:-1, exp_last:-1,   exp_done:-1};
        vt[6] = '{dx:1023, dy:1023, rnd:0, restart:0, exp_cnt:0,    t_vis:0, exp_first:-1, exp_last:-1,   exp_done:2306};

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) run_blit(vt[i]);

        // Abort a blit with reset at cycle 500, then confirm a clean restart.
        va = vt[2];
        launch(va);
        repeat (499) @(posedge clk);
        #1;
        check("busy_before_abort", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        run_blit(vt[0]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
